// File: rtl/denise_bitplane_serializer.sv
// Denise bitplane serializer: per-plane holding and shift registers with odd/even
// scroll delays, feeding an 8-bit colour select at lores/hires/superhires rate.
module denise_bitplane_serializer #(
  parameter int NPL = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           clk7_en,
  input  logic           hires,
  input  logic           shres,
  input  logic [3:0]     nplanes,
  input  logic [NPL-1:0] data_wr,
  input  logic [15:0]    data_in,
  input  logic [3:0]     scroll_odd,
  input  logic [3:0]     scroll_even,
  output logic [7:0]     select
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } arm_state_e;

  arm_state_e  state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        odd_done_q, odd_done_d;
  logic        even_done_q, even_done_d;
  logic [15:0] hold_q  [NPL];
  logic [15:0] shift_q [NPL];
  logic [15:0] shift_d [NPL];
  logic [7:0]  select_q, select_d;

  logic        pix;
  logic        arm;
  logic        load_odd;
  logic        load_even;
  logic [3:0]  nplanes_eff;

  assign arm    = data_wr[0];
  assign select = select_q;

  // Phase counter next state; clk7_en marks phase 0 so the following cycle is phase 1.
  always_comb begin
    phase_d = phase_q;
    if (clk7_en) begin
      phase_d = 2'd1;
    end else begin
      phase_d = phase_q + 2'd1;
    end
  end

  // Pixel tick for the current resolution.
  always_comb begin
    pix = 1'b0;
    if (shres) begin
      pix = 1'b1;
    end else if (hires) begin
      pix = (phase_q == 2'd0) || (phase_q == 2'd2);
    end else begin
      pix = clk7_en;
    end
  end

  // Clamp plane count to the eight available planes.
  always_comb begin
    nplanes_eff = nplanes;
    if (nplanes > 4'd8) begin
      nplanes_eff = 4'd8;
    end else begin
      nplanes_eff = nplanes;
    end
  end

  // Arm/load sequencer; a plane-0 write restarts it and suppresses loads on that cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    odd_done_d  = odd_done_q;
    even_done_d = even_done_q;
    load_odd    = 1'b0;
    load_even   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d     = ST_ARMED;
          cnt_d       = 4'd0;
          odd_done_d  = 1'b0;
          even_done_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (arm) begin
          state_d     = ST_ARMED;
          cnt_d       = 4'd0;
          odd_done_d  = 1'b0;
          even_done_d = 1'b0;
        end else if (pix) begin
          load_odd    = !odd_done_q && (cnt_q == scroll_odd);
          load_even   = !even_done_q && (cnt_q == scroll_even);
          odd_done_d  = odd_done_q | load_odd;
          even_done_d = even_done_q | load_even;
          cnt_d       = cnt_q + 4'd1;
          if (odd_done_d && even_done_d) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ARMED;
          end
        end else begin
          state_d = ST_ARMED;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cnt_d       = 4'd0;
        odd_done_d  = 1'b0;
        even_done_d = 1'b0;
      end
    endcase
  end

  // Shift registers: a load replaces the shift for its plane on that tick.
  always_comb begin
    for (int p = 0; p < NPL; p++) begin
      shift_d[p] = shift_q[p];
      if (pix) begin
        if (((p % 2) == 0) ? load_odd : load_even) begin
          shift_d[p] = hold_q[p];
        end else begin
          shift_d[p] = {shift_q[p][14:0], 1'b0};
        end
      end else begin
        shift_d[p] = shift_q[p];
      end
    end
  end

  // Colour select from the post-load/shift MSBs, masked by the enabled plane count.
  always_comb begin
    select_d = select_q;
    if (pix) begin
      select_d = 8'h00;
      for (int p = 0; p < NPL; p++) begin
        if (4'(p) < nplanes_eff) begin
          select_d[p] = shift_d[p][15];
        end else begin
          select_d[p] = 1'b0;
        end
      end
    end else begin
      select_d = select_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= 2'd0;
      cnt_q       <= 4'd0;
      odd_done_q  <= 1'b0;
      even_done_q <= 1'b0;
      select_q    <= 8'h00;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      odd_done_q  <= odd_done_d;
      even_done_q <= even_done_d;
      select_q    <= select_d;
    end
  end

  // Holding and shift registers; a load on the write cycle sees the old holding value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < NPL; p++) begin
        hold_q[p]  <= 16'h0000;
        shift_q[p] <= 16'h0000;
      end
    end else begin
      for (int p = 0; p < NPL; p++) begin
        if (data_wr[p]) begin
          hold_q[p] <= data_in;
        end
        shift_q[p] <= shift_d[p];
      end
    end
  end

endmodule

// File: tb/tb_denise_bitplane_serializer.sv
// Randomized and directed bench for denise_bitplane_serializer against a
// word/age behavioural model of the bitplane pixel output.
module tb_denise_bitplane_serializer;

  localparam int NPL = 8;

  logic        clk;
  logic        reset_n;
  logic        clk7_en;
  logic        hires;
  logic        shres;
  logic [3:0]  nplanes;
  logic [7:0]  data_wr;
  logic [15:0] data_in;
  logic [3:0]  scroll_odd;
  logic [3:0]  scroll_even;
  logic [7:0]  select;

  int checks = 0;
  int errors = 0;

  denise_bitplane_serializer #(.NPL(NPL)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clk7_en     (clk7_en),
    .hires       (hires),
    .shres       (shres),
    .nplanes     (nplanes),
    .data_wr     (data_wr),
    .data_in     (data_in),
    .scroll_odd  (scroll_odd),
    .scroll_even (scroll_even),
    .select      (select)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: each plane outputs bit (15 - age) of the word it last loaded, 0 once age reaches 16.
  logic [15:0] m_hold [NPL];
  logic [15:0] m_word [NPL];
  int          m_age  [NPL];
  bit          m_armed;
  int          m_k;
  bit          m_odd_done;
  bit          m_even_done;
  logic [7:0]  m_sel;
  bit          m_pix;
  int          cyc;
  logic [7:0]  tick_sel [64];

  task automatic m_reset();
    for (int p = 0; p < NPL; p++) begin
      m_hold[p] = 16'h0000;
      m_word[p] = 16'h0000;
      m_age[p]  = 16;
    end
    m_armed     = 1'b0;
    m_k         = 0;
    m_odd_done  = 1'b0;
    m_even_done = 1'b0;
    m_sel       = 8'h00;
    m_pix       = 1'b0;
    cyc         = 0;
  endtask

  task automatic model_step();
    bit pix;
    bit lo;
    bit le;
    int ph;
    int np;
    if (!reset_n) begin
      m_reset();
      return;
    end
    ph = cyc % 4;
    if (shres)      pix = 1'b1;
    else if (hires) pix = (ph == 0) || (ph == 2);
    else            pix = (ph == 0);
    lo = 1'b0;
    le = 1'b0;
    if (data_wr[0]) begin
      m_armed     = 1'b1;
      m_k         = 0;
      m_odd_done  = 1'b0;
      m_even_done = 1'b0;
    end else if (m_armed && pix) begin
      lo = !m_odd_done && (m_k == int'(scroll_odd));
      le = !m_even_done && (m_k == int'(scroll_even));
      m_odd_done  = m_odd_done | lo;
      m_even_done = m_even_done | le;
      m_k = (m_k + 1) % 16;
      if (m_odd_done && m_even_done) m_armed = 1'b0;
    end
    np = (nplanes > 4'd8) ? 8 : int'(nplanes);
    if (pix) begin
      for (int p = 0; p < NPL; p++) begin
        if (((p % 2) == 0) ? lo : le) begin
          m_word[p] = m_hold[p];
          m_age[p]  = 0;
        end else if (m_age[p] < 16) begin
          m_age[p] = m_age[p] + 1;
        end
      end
      for (int p = 0; p < NPL; p++) begin
        m_sel[p] = (p < np && m_age[p] < 16) ? m_word[p][15 - m_age[p]] : 1'b0;
      end
    end
    for (int p = 0; p < NPL; p++) begin
      if (data_wr[p]) m_hold[p] = data_in;
    end
    m_pix = pix;
    cyc   = cyc + 1;
  endtask

  task automatic lit_check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // One clock: advance the model, let the DUT take the edge, compare on the falling edge.
  task automatic cycle();
    clk7_en = reset_n && ((cyc % 4) == 0);
    model_step();
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (select !== m_sel) begin
      errors++;
      $display("FAIL cycle_compare t=%0t select=%h expected=%h", $time, select, m_sel);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    data_wr = 8'h00;
    idle(3);
    reset_n = 1'b1;
  endtask

  task automatic write(input logic [7:0] wr, input logic [15:0] d);
    data_wr = wr;
    data_in = d;
    cycle();
    data_wr = 8'h00;
  endtask

  task automatic run_ticks(input int n);
    int got;
    got = 0;
    for (int c = 0; c < n * 4 + 16 && got < n; c++) begin
      cycle();
      if (m_pix) begin
        got++;
        tick_sel[got] = select;
      end
    end
    if (got < n) begin
      checks++;
      errors++;
      $display("FAIL tick_budget got=%0d expected=%0d", got, n);
    end
  endtask

  initial begin
    logic [5:0] pat;
    logic [7:0] e;
    reset_n = 1'b0; clk7_en = 1'b0; hires = 1'b0; shres = 1'b0;
    nplanes = 4'd1; data_wr = 8'h00; data_in = 16'h0000;
    scroll_odd = 4'd0; scroll_even = 4'd0;
    m_reset();

    do_reset();
    lit_check("reset_select", select, 8'h00);

    // Lores, scroll 0, one plane: 1,0,1,0 then zeros.
    idle(5);
    write(8'h01, 16'hA000);
    run_ticks(6);
    pat = 6'b101000;
    for (int t = 1; t <= 6; t++)
      lit_check($sformatf("lores_tick%0d", t), tick_sel[t], {7'b0, pat[6 - t]});

    // Hires, odd scroll 0, even scroll 3.
    hires = 1'b1; nplanes = 4'd2; scroll_even = 4'd3;
    do_reset();
    write(8'h02, 16'hFFFF);
    write(8'h01, 16'hFFFF);
    run_ticks(20);
    for (int t = 1; t <= 20; t++) begin
      e = {6'b0, (t >= 4 && t <= 19), (t <= 16)};
      lit_check($sformatf("hires_tick%0d", t), tick_sel[t], e);
    end

    // Superhires: one-clock pulse on all planes.
    hires = 1'b0; shres = 1'b1; nplanes = 4'd8; scroll_even = 4'd0;
    do_reset();
    write(8'hFF, 16'h8000);
    cycle();
    lit_check("shres_pulse", select, 8'hFF);
    cycle();
    lit_check("shres_after", select, 8'h00);

    // Four planes enabled out of eight loaded.
    shres = 1'b0; nplanes = 4'd4;
    do_reset();
    write(8'hFF, 16'hFFFF);
    run_ticks(3);
    for (int t = 1; t <= 3; t++)
      lit_check($sformatf("np4_tick%0d", t), tick_sel[t], 8'h0F);

    // Re-arm with odd scroll 5: only the second arm loads.
    nplanes = 4'd1; scroll_odd = 4'd5;
    do_reset();
    write(8'h01, 16'h8000);
    run_ticks(2);
    write(8'h01, 16'h8000);
    run_ticks(8);
    for (int t = 1; t <= 8; t++)
      lit_check($sformatf("rearm_tick%0d", t), tick_sel[t], {7'b0, (t == 6)});

    // Asynchronous reset mid-word.
    nplanes = 4'd8; scroll_odd = 4'd0;
    do_reset();
    write(8'hFF, 16'hFFFF);
    run_ticks(3);
    lit_check("pre_reset_word", tick_sel[3], 8'hFF);
    reset_n = 1'b0;
    #1;
    lit_check("async_reset", select, 8'h00);
    m_reset();
    idle(2);
    reset_n = 1'b1;
    idle(40);
    lit_check("post_reset_idle", select, 8'h00);

    // Randomized modes, plane counts, scrolls and writes.
    for (int seg = 0; seg < 20; seg++) begin
      hires       = 1'($urandom_range(0, 1));
      shres       = ($urandom_range(0, 3) == 0);
      nplanes     = 4'($urandom_range(0, 15));
      scroll_odd  = 4'($urandom_range(0, 15));
      scroll_even = 4'($urandom_range(0, 15));
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 5) == 0) data_wr = 8'($urandom);
        else                           data_wr = 8'h00;
        data_in = 16'($urandom);
        cycle();
      end
      data_wr = 8'h00;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
